// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch front end driving a synchronous instruction memory.
// Owns the PC and tracks which PC the registered memory output belongs to.
// It handles boot hold-off, stall, redirect and halt.
// Optional build macro FETCH_MISALIGN_CHK_EN: a redirect to a misaligned target raises a
// one-cycle misalign_o pulse and parks the unit in HALT.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               halt_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [31:0]        imem_pc_o,
  output logic               imem_read_en_o,
  output logic               imem_flush_o,
  output logic [31:0]        if_pc_o,
  output logic [31:0]        if_pc_plus4_o,
  output logic               if_valid_o,
  output logic [COUNT_W-1:0] fetch_count_o,
  output logic               misalign_o
);

  localparam int unsigned BOOT_W = 8;
  localparam logic [BOOT_W-1:0] BOOT_LAST =
    (BOOT_CYCLES == 0) ? '0 : BOOT_W'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // With no boot hold-off the unit is already in RUN on the first cycle after reset
  localparam state_t RESET_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

  state_t              state;
  state_t              state_next;
  logic [BOOT_W-1:0]   boot_cnt;
  logic [31:0]         pc;
  logic [31:0]         redirect_aligned;
  logic                boot_done;
  logic                bad_target;
  logic                do_read;
  logic                do_redirect;

  assign redirect_aligned = {redirect_pc_i[31:2], 2'b00};
  assign boot_done        = (boot_cnt == BOOT_LAST);

`ifdef FETCH_MISALIGN_CHK_EN
  assign bad_target = |redirect_pc_i[1:0];
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc_i[1:0];
  assign bad_target      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_next;
  end

  // Next-state and memory-control decode; redirect outranks halt, which outranks stall
  always_comb begin
    state_next  = state;
    do_read     = 1'b0;
    do_redirect = 1'b0;
    if (!rst) begin
      do_redirect = redirect_i;
      unique case (state)
        ST_BOOT: begin
          if (boot_done) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (redirect_i)   state_next = ST_RUN;
          else if (halt_i)  state_next = ST_HALT;
          else if (!stall_i) do_read   = 1'b1;
        end
        ST_HALT: begin
          if (redirect_i) state_next = ST_RUN;
        end
        default: state_next = RESET_STATE;
      endcase
      if (redirect_i && bad_target) state_next = ST_HALT;
    end
  end

  assign imem_read_en_o = do_read;
  assign imem_flush_o   = do_redirect;
  assign imem_pc_o      = pc;

  // Boot hold-off counter; advances every BOOT cycle regardless of redirects
  always_ff @(posedge clk) begin
    if (rst)                   boot_cnt <= '0;
    else if (state == ST_BOOT) boot_cnt <= boot_cnt + BOOT_W'(1);
  end

  // Program counter: redirect target, or sequential advance on each fetch
  always_ff @(posedge clk) begin
    if (rst)              pc <= RESET_PC;
    else if (do_redirect) pc <= redirect_aligned;
    else if (do_read)     pc <= pc + 32'd4;
  end

  // Tag for the memory output: PC of the fetched word and its validity
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc_o       <= RESET_PC;
      if_pc_plus4_o <= RESET_PC + 32'd4;
      if_valid_o    <= 1'b0;
    end else if (do_redirect) begin
      if_valid_o    <= 1'b0;
    end else if (do_read) begin
      if_pc_o       <= pc;
      if_pc_plus4_o <= pc + 32'd4;
      if_valid_o    <= 1'b1;
    end else if (state == ST_RUN && halt_i) begin
      if_valid_o    <= 1'b0;
    end
  end

  // Count of fetches issued; wraps naturally
  always_ff @(posedge clk) begin
    if (rst)          fetch_count_o <= '0;
    else if (do_read) fetch_count_o <= fetch_count_o + COUNT_W'(1);
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // One-cycle flag following a misaligned redirect
  always_ff @(posedge clk) begin
    if (rst) misalign_o <= 1'b0;
    else     misalign_o <= do_redirect && bad_target;
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios then random traffic,
// each cycle compared against a behavioural fetch model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          BC  = 2;

  logic        clk = 1'b0;
  logic        rst, stall, halt, redir;
  logic [31:0] rpc;
  logic [31:0] imem_pc, if_pc, if_pc_plus4, fetch_count;
  logic        read_en, flush, if_valid, misalign;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ifpc, m_cnt;
  logic        m_valid, m_mis, m_halted;
  int          m_boot;

  fetch_pc_unit #(.RESET_PC(RPC), .BOOT_CYCLES(BC), .COUNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .halt_i(halt),
    .redirect_i(redir), .redirect_pc_i(rpc),
    .imem_pc_o(imem_pc), .imem_read_en_o(read_en), .imem_flush_o(flush),
    .if_pc_o(if_pc), .if_pc_plus4_o(if_pc_plus4), .if_valid_o(if_valid),
    .fetch_count_o(fetch_count), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_ifpc = RPC; m_cnt = 0; m_valid = 0; m_mis = 0;
    m_halted = 0; m_boot = BC;
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered ones
  task automatic step(input logic r, input logic s, input logic h,
                      input logic d, input logic [31:0] t);
    logic exp_rd;
    rst = r; stall = s; halt = h; redir = d; rpc = t;
    #1;
    exp_rd = !r && !m_halted && (m_boot == 0) && !s && !h && !d;
    chk("read_en", 32'(read_en), 32'(exp_rd));
    chk("flush", 32'(flush), 32'(!r && d));
    @(posedge clk);
    m_mis = 0;
    if (r) model_reset();
    else if (d) begin
      m_pc = t & 32'hFFFF_FFFC;
      m_valid = 0;
      m_halted = 0;
      if (m_boot > 0) m_boot--;
`ifdef FETCH_MISALIGN_CHK_EN
      if (t[1:0] != 2'b00) begin m_mis = 1; m_halted = 1; m_boot = 0; end
`endif
    end
    else if (m_boot > 0) m_boot--;
    else if (m_halted) begin end
    else if (h) begin m_valid = 0; m_halted = 1; end
    else if (s) begin end
    else begin
      m_ifpc = m_pc; m_pc = m_pc + 32'd4; m_valid = 1; m_cnt = m_cnt + 1;
    end
    @(negedge clk);
    chk("pc", imem_pc, m_pc);
    chk("if_pc", if_pc, m_ifpc);
    chk("if_pc_plus4", if_pc_plus4, m_ifpc + 32'd4);
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    chk("fetch_count", fetch_count, m_cnt);
    chk("misalign", 32'(misalign), 32'(m_mis));
  endtask

  initial begin
    model_reset();
    // Reset held with activity on inputs: controls stay quiet
    step(1, 0, 0, 1, 32'h1234_5678);
    step(1, 0, 0, 0, 0);
    chk("rst_pc", imem_pc, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    // Boot hold-off then sequential fetch 0,4,8
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("tp_first_ifpc", if_pc, 32'h0);
    chk("tp_first_cnt", fetch_count, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("tp_pc8", imem_pc, 32'h8);
    // Stall three cycles, then resume at 0x8
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("tp_stall_pc", imem_pc, 32'h8);
    chk("tp_stall_ifpc", if_pc, 32'h4);
    step(0, 0, 0, 0, 0);
    chk("tp_resume_ifpc", if_pc, 32'h8);
    // Redirect with stall
    step(0, 1, 0, 1, 32'h40);
    chk("tp_redir_pc", imem_pc, 32'h40);
    step(0, 0, 0, 0, 0);
    chk("tp_redir_ifpc", if_pc, 32'h40);
    // Halt pulse then 10 idle cycles, then redirect to 0x100
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h100);
    step(0, 0, 0, 0, 0);
    chk("tp_halt_exit", if_pc, 32'h100);
    // Wrap at the top of the address space
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    chk("tp_wrap_pc", imem_pc, 32'h0);
    chk("tp_wrap_plus4", if_pc_plus4, 32'h0);
    // Misaligned target
    step(0, 0, 0, 1, 32'h42);
    chk("tp_mis_pc", imem_pc, 32'h40);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Redirect during boot
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h200);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Random traffic including occasional mid-run resets
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      case ($urandom_range(0, 3))
        0:       t = $urandom;
        1:       t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: t = 32'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0), t);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end; sits directly upstream of the synchronous instruction memory.
- Owns the program counter and drives the memory's pc, read_en and flush inputs.
- Tracks which PC the registered memory output belongs to and presents if_pc/if_valid to decode alongside the memory's instruction.
- Handles boot hold-off, stall, redirect (branch/jump/trap) and halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BOOT_CYCLES, 2, cycles after reset release before the first fetch; range 0..255.
- COUNT_W, 32, width of the fetch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- stall_i  in  1  decode/hazard back-pressure; hold the current fetch.
- halt_i  in  1  stop fetching (ebreak/wfi from downstream).
- redirect_i  in  1  PC redirect request.
- redirect_pc_i  in  32  redirect target.
- imem_pc_o  out  32  byte address to instruction memory; equals PC register.
- imem_read_en_o  out  1  memory read enable; combinational.
- imem_flush_o  out  1  memory flush; combinational.
- if_pc_o  out  32  PC of the instruction currently on the memory output.
- if_pc_plus4_o  out  32  if_pc_o + 4, mod 2^32.
- if_valid_o  out  1  memory output is a real fetched instruction.
- fetch_count_o  out  COUNT_W  number of fetches issued; wraps.
- misalign_o  out  1  misaligned redirect flag; see Optional Feature.

Behaviour:
- Reset is synchronous and active-high (rst), on clock clk.
- Values held while rst=1:
  - pc = RESET_PC, if_pc_o = RESET_PC, if_valid_o = 0, fetch_count_o = 0, misalign_o = 0.
  - state = BOOT, boot counter = 0.
  - imem_read_en_o and imem_flush_o forced to 0.
- Memory timing: the memory captures mem[pc] at the edge where read_en=1. The instruction is visible the following cycle; flush zeroes it at the edge.
- States BOOT, RUN, HALT.
- BOOT:
  - read_en = 0.
  - Counter increments each cycle; moves to RUN at the edge where counter == BOOT_CYCLES-1.
  - BOOT_CYCLES = 0: state is RUN in the first cycle after reset release.
  - Redirect during BOOT loads pc (flush still asserted); the boot count is unaffected.
- RUN:
  - imem_read_en_o = !stall_i && !redirect_i && !halt_i.
  - On a read edge: pc <= pc+4 (wraps at 2^32), if_pc_o <= pc, if_valid_o <= 1, fetch_count_o += 1.
- stall_i=1 (no redirect): read_en = 0; pc, if_pc_o, if_valid_o and fetch_count_o hold. The memory output holds.
- Redirect:
  - redirect_i=1 gives imem_flush_o = 1 that cycle.
  - At the edge: pc <= {redirect_pc_i[31:2], 2'b00}, if_valid_o <= 0, if_pc_o unchanged.
  - Redirect beats stall and halt.
  - Redirect in HALT returns to RUN.
- halt_i=1 in RUN (no redirect): read_en = 0; at the edge if_valid_o <= 0 and state <= HALT. Takes priority over stall_i.
- HALT: read_en = 0, pc holds; stays until redirect.
- Redirect seen by a stalled decode: the instruction is lost by design; decode discards it because if_valid_o = 0.
- Reset mid-operation: all state returns to reset values at the next edge; no fetch is issued in that cycle.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - Redirect with redirect_pc_i[1:0] != 0 still loads the aligned pc.
  - misalign_o = 1 for exactly one cycle after that edge.
  - state <= HALT instead of RUN.
- Undefined:
  - Low bits are silently dropped and state follows normal redirect rules.
  - misalign_o tied to 0.

Test Plan:
- Reset, BOOT_CYCLES=2, no stall -> read_en=0 for 2 cycles after release, then pc_o 0,4,8 on successive cycles; if_pc_o=0 with if_valid_o=1 one cycle after first read; fetch_count_o=1.
- Stall held 3 cycles while pc_o=0x8 -> read_en=0, pc_o stays 0x8, if_pc_o stays 0x4, if_valid_o=1, fetch_count_o unchanged; fetch resumes at 0x8 on release.
- redirect_i=1 to 0x40 with stall_i=1 in the same cycle -> flush=1, read_en=0; next cycle pc_o=0x40, if_valid_o=0; cycle after, if_pc_o=0x40, if_valid_o=1.
- halt_i pulse in RUN -> if_valid_o=0, read_en stays 0 for 10 cycles; redirect to 0x100 -> RUN, first fetch at 0x100.
- Redirect to 0xFFFF_FFFC -> fetch at 0xFFFF_FFFC, next pc_o=0x0000_0000, if_pc_plus4_o=0x0 for that instruction.
- Redirect to 0x42 -> pc_o=0x40. With FETCH_MISALIGN_CHK_EN: one-cycle misalign_o pulse and HALT. Without: misalign_o=0 and fetch continues at 0x40.
